// File: rtl/mat_burst_tx.sv
// Burst initiator: buffers upstream words in a FIFO and sends full BURST_LEN bursts via req/ack then gap-free vld/data.
// Optional macro MAT_BURST_TX_FLUSH_EN adds a flush input that sends a partial burst padded with zeros.
module mat_burst_tx #(
    parameter int DW        = 32,
    parameter int BURST_LEN = 64,
    parameter int DEPTH     = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     src_vld,
    input  logic [DW-1:0]            src_data,
    output logic                     src_rdy,
    output logic                     bus_req,
    input  logic                     bus_ack,
    output logic                     bus_vld,
    output logic [DW-1:0]            bus_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     burst_done,
`ifdef MAT_BURST_TX_FLUSH_EN
    input  logic                     flush,
`endif
    output logic [1:0]               dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST_LEN);
    localparam int LW = AW + 1;
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_XFER = 2'd2} state_t;

    // Handshakes: upstream push = src_vld & src_rdy; burst start = bus_req & bus_ack at a rising edge.
    state_t            state_q, state_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [BW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              bus_req_q, bus_req_d, bus_vld_q, bus_vld_d;
    logic              burst_done_q, burst_done_d;
    logic [DW-1:0]     bus_data_q, bus_data_d;
    logic              push, pop, real_word;
    logic [DW-1:0]     mem [DEPTH];
`ifdef MAT_BURST_TX_FLUSH_EN
    logic              flush_q, flush_d;
    logic [LW-1:0]     avail_q, avail_d;
`endif

    assign src_rdy    = (level_q != LW'(DEPTH));
    assign push       = src_vld && src_rdy;
    assign cnt_inc    = cnt_q + 1'b1;
    assign bus_req    = bus_req_q;
    assign bus_vld    = bus_vld_q;
    assign bus_data   = bus_data_q;
    assign burst_done = burst_done_q;
    assign level      = level_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = 1'b0;
        bus_vld_d    = 1'b0;
        bus_data_d   = '0;
        burst_done_d = 1'b0;
        pop          = 1'b0;
        real_word    = 1'b1;
`ifdef MAT_BURST_TX_FLUSH_EN
        flush_d      = flush_q;
        avail_d      = avail_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (level_q >= LW'(BURST_LEN)) begin
                    state_d   = S_REQ;
                    bus_req_d = 1'b1;
`ifdef MAT_BURST_TX_FLUSH_EN
                    flush_d   = 1'b0;
                end else if (flush && level_q != '0) begin
                    // Only the words buffered now belong to this burst; later pushes wait.
                    state_d   = S_REQ;
                    bus_req_d = 1'b1;
                    flush_d   = 1'b1;
                    avail_d   = level_q;
`endif
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    // Word 0 is popped on the handshake edge so it appears in the next cycle.
                    state_d    = S_XFER;
                    cnt_d      = '0;
                    pop        = 1'b1;
                    bus_vld_d  = 1'b1;
                    bus_data_d = mem[rd_ptr_q];
                end else begin
                    bus_req_d = 1'b1;
                end
            end
            S_XFER: begin
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d        = cnt_inc;
                    bus_vld_d    = 1'b1;
                    burst_done_d = (cnt_inc == LAST);
`ifdef MAT_BURST_TX_FLUSH_EN
                    real_word    = !flush_q || (LW'(cnt_inc) < avail_q);
`endif
                    if (real_word) begin
                        pop        = 1'b1;
                        bus_data_d = mem[rd_ptr_q];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_vld_q    <= 1'b0;
            bus_data_q   <= '0;
            burst_done_q <= 1'b0;
`ifdef MAT_BURST_TX_FLUSH_EN
            flush_q      <= 1'b0;
            avail_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_vld_q    <= bus_vld_d;
            bus_data_q   <= bus_data_d;
            burst_done_q <= burst_done_d;
`ifdef MAT_BURST_TX_FLUSH_EN
            flush_q      <= flush_d;
            avail_q      <= avail_d;
`endif
        end
    end

    // Storage needs no reset: stale entries are never read once the pointers clear.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= src_data;
    end
endmodule

// File: tb/tb_mat_burst_tx.sv
// Directed bench for mat_burst_tx: full bursts, threshold, backpressure, continuous refill with pointer wrap, mid-burst reset.
module tb_mat_burst_tx;
    localparam int DW = 32;
    localparam int BL = 64;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_vld;
    logic [DW-1:0] src_data;
    logic          src_rdy;
    logic          bus_req;
    logic          bus_ack;
    logic          bus_vld;
    logic [DW-1:0] bus_data;
    logic [7:0]    level;
    logic          burst_done;
    logic [1:0]    dbg_state;
`ifdef MAT_BURST_TX_FLUSH_EN
    logic          flush;
`endif

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] next_word;

    mat_burst_tx #(.DW(DW), .BURST_LEN(BL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
        .bus_req(bus_req), .bus_ack(bus_ack), .bus_vld(bus_vld), .bus_data(bus_data),
        .level(level), .burst_done(burst_done),
`ifdef MAT_BURST_TX_FLUSH_EN
        .flush(flush),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src_vld  = 1'b1;
        src_data = w;
        if (src_rdy) exp_q.push_back(w);
        step();
        src_vld = 1'b0;
    endtask

    task automatic drive_push(input bit keep);
        if (keep) begin
            src_vld  = 1'b1;
            src_data = next_word;
            if (src_rdy) begin
                exp_q.push_back(next_word);
                next_word++;
            end
        end else begin
            src_vld = 1'b0;
        end
    endtask

    // Waits for a burst, checks n_words against the expected queue; a full burst also checks the trailing gap.
    task automatic collect(input string tag, input int n_words, input bit keep_push, output int req_cycles);
        int wait_cyc;
        logic [DW-1:0] exp_w;
        logic [7:0] lvl0;
        wait_cyc   = 0;
        req_cycles = 0;
        while (bus_vld !== 1'b1 && wait_cyc < 300) begin
            if (bus_req === 1'b1) req_cycles++;
            drive_push(keep_push);
            step();
            wait_cyc++;
        end
        check({tag, " start"}, 32'(bus_vld), 32'd1);
        if (bus_vld === 1'b1) begin
            lvl0 = level;
            for (int k = 0; k < n_words; k++) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check($sformatf("%s vld[%0d]", tag, k), 32'(bus_vld), 32'd1);
                check($sformatf("%s data[%0d]", tag, k), bus_data, exp_w);
                check($sformatf("%s done[%0d]", tag, k), 32'(burst_done), 32'(k == BL - 1));
                check($sformatf("%s req[%0d]", tag, k), 32'(bus_req), 32'd0);
                if (keep_push) check($sformatf("%s level[%0d]", tag, k), 32'(level), 32'(lvl0));
                if (k < n_words - 1 || n_words == BL) begin
                    drive_push(keep_push);
                    step();
                end
            end
            if (n_words == BL) begin
                check({tag, " gap vld"}, 32'(bus_vld), 32'd0);
                check({tag, " gap req"}, 32'(bus_req), 32'd0);
                check({tag, " gap done"}, 32'(burst_done), 32'd0);
            end
        end
        src_vld = 1'b0;
    endtask

    initial begin
        int rc;
        bit seen;
        rst       = 1'b1;
        src_vld   = 1'b0;
        src_data  = '0;
        bus_ack   = 1'b0;
        next_word = 32'h400;
`ifdef MAT_BURST_TX_FLUSH_EN
        flush     = 1'b0;
`endif
        step();
        step();
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_vld", 32'(bus_vld), 32'd0);
        check("rst bus_data", bus_data, 32'd0);
        check("rst burst_done", 32'(burst_done), 32'd0);
        check("rst level", 32'(level), 32'd0);
        check("rst src_rdy", 32'(src_rdy), 32'd1);
        rst = 1'b0;
        step();

        // Single burst, zero-wait ack.
        bus_ack = 1'b1;
        for (int i = 0; i < BL; i++) push_word(32'(i));
        collect("b1", BL, 1'b0, rc);
        check("b1 req_cycles", 32'(rc), 32'd1);
        check("b1 level_after", 32'(level), 32'd0);

        // 63 words never trigger, even with ack held high.
        for (int i = 0; i < BL - 1; i++) push_word(32'h100 + 32'(i));
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_req === 1'b1 || bus_vld === 1'b1) seen = 1'b1;
            step();
        end
        check("b2 no_req", 32'(seen), 32'd0);
        check("b2 level63", 32'(level), 32'd63);
        push_word(32'h13F);
        collect("b2", BL, 1'b0, rc);
        check("b2 req_cycles", 32'(rc), 32'd1);

        // Fill to full with ack low; overflow word is dropped.
        bus_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(32'(i));
        check("full level", 32'(level), 32'd128);
        check("full src_rdy", 32'(src_rdy), 32'd0);
        check("full bus_req", 32'(bus_req), 32'd1);
        push_word(32'hDEAD);
        check("full dropped", 32'(level), 32'd128);
        check("full no_vld", 32'(bus_vld), 32'd0);
        bus_ack = 1'b1;
        collect("b3a", BL, 1'b0, rc);
        collect("b3b", BL, 1'b0, rc);
        check("b3b req_cycles", 32'(rc), 32'd1);
        check("b3 level_after", 32'(level), 32'd0);

        // Continuous refill during bursts; third burst reads across the pointer wrap.
        bus_ack = 1'b0;
        for (int i = 0; i < 96; i++) push_word(32'h300 + 32'(i));
        check("b4 level96", 32'(level), 32'd96);
        bus_ack = 1'b1;
        collect("b4a", BL, 1'b1, rc);
        collect("b4b", BL, 1'b1, rc);
        collect("b4c", 20, 1'b0, rc);

        // Reset in the middle of the third burst.
        rst = 1'b1;
        step();
        check("mid rst bus_req", 32'(bus_req), 32'd0);
        check("mid rst bus_vld", 32'(bus_vld), 32'd0);
        check("mid rst bus_data", bus_data, 32'd0);
        check("mid rst burst_done", 32'(burst_done), 32'd0);
        check("mid rst level", 32'(level), 32'd0);
        check("mid rst src_rdy", 32'(src_rdy), 32'd1);
        check("mid rst state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_vld === 1'b1 || bus_req === 1'b1) seen = 1'b1;
            step();
        end
        check("post rst quiet", 32'(seen), 32'd0);
        check("post rst level", 32'(level), 32'd0);

`ifdef MAT_BURST_TX_FLUSH_EN
        // Partial burst: ten words then zero padding.
        for (int i = 0; i < 10; i++) push_word(32'hA0 + 32'(i));
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < BL - 10; i++) exp_q.push_back('0);
        collect("flush", BL, 1'b0, rc);
        check("flush level_after", 32'(level), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
